// File: rtl/eng_ctrl_pkg.sv
// rtl/eng_ctrl_pkg.sv - shared types and sizing for the erasure-coding job sequencer
package eng_ctrl_pkg;

    localparam int ENG_M_MAX     = 128;
    localparam int ENG_PCK_XOR_N = 2;
    localparam int ENG_GRP_W     = $clog2(ENG_M_MAX);
    localparam int ENG_PKT_W     = 16;

    typedef enum logic [2:0] {
        IDLE,
        BM_REQ,
        BM_WAIT,
        CALC,
        DRAIN,
        DONE
    } eng_seq_state_t;

endpackage

// File: rtl/eng_ctrl_cnt.sv
// rtl/eng_ctrl_cnt.sv - loadable/clearable up-counter with terminal-count flag
module eng_ctrl_cnt #(
    parameter int W = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         ld,
    input  logic [W-1:0] ld_val,
    input  logic         inc,
    input  logic [W-1:0] tc_val,
    output logic [W-1:0] cnt,
    output logic         tc
);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (ld) begin
            cnt <= ld_val;
        end else if (inc) begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tc = (cnt == tc_val);

endmodule

// File: rtl/eng_seq_ctrl.sv
// rtl/eng_seq_ctrl.sv - stripe job sequencer driving BM load, packet streaming and drain per group
module eng_seq_ctrl
    import eng_ctrl_pkg::*;
#(
    parameter int GRP_W = ENG_GRP_W,
    parameter int PKT_W = ENG_PKT_W
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             job_start,
    input  logic             job_abort,
    input  logic [GRP_W-1:0] job_grp_num,
    input  logic [PKT_W-1:0] job_pkt_num,
    output logic             job_busy,
    output logic             job_done,
    output logic             ctl_err,
    output logic             ctl_bm_rd_req,
    output logic [GRP_W-1:0] ctl_bm_rd_idx,
    input  logic             bm_ctl_rd_val,
    input  logic             inbuf_ctl_val,
    output logic             ctl_inbuf_rewind,
    input  logic             outbuf_ctl_full,
    output logic             ctl_eng_bm_val,
    output logic             ctl_eng_gl_wr_en,
    output logic             ctl_eng_din_val,
    output logic             ctl_eng_calc_en,
    input  logic             eng_ctl_data_used,
    input  logic             eng_ctl_pl_empty
);

    eng_seq_state_t   state, state_nx;
    logic [GRP_W-1:0] grp_num_q, grp_cnt;
    logic [PKT_W-1:0] pkt_num_q, used_cnt;
    logic             grp_tc, used_tc;
    logic             grp_inc, grp_clr, used_inc, used_clr;
    logic             cfg_ld, err_set, err_clr, pl_empty_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            job_busy   <= 1'b0;
            ctl_err    <= 1'b0;
            pl_empty_q <= 1'b0;
            grp_num_q  <= '0;
            pkt_num_q  <= '0;
        end else begin
            state      <= state_nx;
            job_busy   <= (state_nx != IDLE);
            pl_empty_q <= eng_ctl_pl_empty;
            if (err_clr) begin
                ctl_err <= 1'b0;
            end else if (err_set) begin
                ctl_err <= 1'b1;
            end
            if (cfg_ld) begin
                grp_num_q <= job_grp_num;
                pkt_num_q <= job_pkt_num;
            end
        end
    end

    always_comb begin
        state_nx         = state;
        job_done         = 1'b0;
        ctl_bm_rd_req    = 1'b0;
        ctl_inbuf_rewind = 1'b0;
        ctl_eng_bm_val   = 1'b0;
        ctl_eng_gl_wr_en = 1'b0;
        ctl_eng_din_val  = 1'b0;
        ctl_eng_calc_en  = 1'b0;
        grp_inc          = 1'b0;
        grp_clr          = 1'b0;
        used_inc         = 1'b0;
        used_clr         = 1'b0;
        cfg_ld           = 1'b0;
        err_set          = 1'b0;
        err_clr          = 1'b0;
        case (state)
            IDLE: begin
                if (job_start) begin
                    err_clr  = 1'b1;
                    grp_clr  = 1'b1;
                    used_clr = 1'b1;
                    if (job_grp_num == '0 || job_pkt_num == '0) begin
                        state_nx = DONE;
                    end else begin
                        cfg_ld   = 1'b1;
                        state_nx = BM_REQ;
                    end
                end
            end
            BM_REQ: begin
                ctl_bm_rd_req = 1'b1;
                state_nx      = BM_WAIT;
            end
            BM_WAIT: begin
                if (bm_ctl_rd_val) begin
                    ctl_eng_bm_val   = 1'b1;
                    ctl_eng_gl_wr_en = 1'b1;
                    state_nx         = CALC;
                end
            end
            CALC: begin
                ctl_eng_calc_en = ~outbuf_ctl_full;
                ctl_eng_din_val = inbuf_ctl_val & ~outbuf_ctl_full;
                // A consume without offered data is a protocol error and never counts
                if (eng_ctl_data_used) begin
                    if (ctl_eng_din_val) begin
                        used_inc = 1'b1;
                        if (used_tc) begin
                            state_nx = DRAIN;
                        end
                    end else begin
                        err_set = 1'b1;
                    end
                end
            end
            DRAIN: begin
                ctl_eng_calc_en = ~outbuf_ctl_full;
                if (pl_empty_q) begin
                    if (grp_tc) begin
                        state_nx = DONE;
                    end else begin
                        grp_inc          = 1'b1;
                        used_clr         = 1'b1;
                        ctl_inbuf_rewind = 1'b1;
                        state_nx         = BM_REQ;
                    end
                end
            end
            DONE: begin
                job_done = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
        // Abort wins over everything: quiet the strobes and reset the walk
        if (job_abort && state != IDLE) begin
            state_nx         = IDLE;
            job_done         = 1'b0;
            ctl_bm_rd_req    = 1'b0;
            ctl_inbuf_rewind = 1'b0;
            ctl_eng_bm_val   = 1'b0;
            ctl_eng_gl_wr_en = 1'b0;
            ctl_eng_din_val  = 1'b0;
            ctl_eng_calc_en  = 1'b0;
            grp_inc          = 1'b0;
            used_inc         = 1'b0;
            grp_clr          = 1'b1;
            used_clr         = 1'b1;
            err_set          = 1'b0;
        end
    end

    assign ctl_bm_rd_idx = ctl_bm_rd_req ? grp_cnt : '0;

    eng_ctrl_cnt #(.W(GRP_W)) u_grp_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (grp_clr),
        .ld     (1'b0),
        .ld_val ('0),
        .inc    (grp_inc),
        .tc_val (grp_num_q - 1'b1),
        .cnt    (grp_cnt),
        .tc     (grp_tc)
    );

    eng_ctrl_cnt #(.W(PKT_W)) u_used_cnt (
        .clk    (clk),
        .rst_n  (rst_n),
        .clr    (used_clr),
        .ld     (1'b0),
        .ld_val ('0),
        .inc    (used_inc),
        .tc_val (pkt_num_q - 1'b1),
        .cnt    (used_cnt),
        .tc     (used_tc)
    );

endmodule

// File: tb/tb_eng_seq_ctrl.sv
// tb/tb_eng_seq_ctrl.sv - directed self-checking bench for eng_seq_ctrl
module tb_eng_seq_ctrl;
    import eng_ctrl_pkg::*;

    localparam int GW = ENG_GRP_W;
    localparam int PW = ENG_PKT_W;

    logic          clk = 1'b0;
    logic          rst_n;
    logic          job_start, job_abort;
    logic [GW-1:0] job_grp_num;
    logic [PW-1:0] job_pkt_num;
    logic          job_busy, job_done, ctl_err;
    logic          ctl_bm_rd_req;
    logic [GW-1:0] ctl_bm_rd_idx;
    logic          bm_ctl_rd_val, inbuf_ctl_val, ctl_inbuf_rewind, outbuf_ctl_full;
    logic          ctl_eng_bm_val, ctl_eng_gl_wr_en, ctl_eng_din_val, ctl_eng_calc_en;
    logic          eng_ctl_data_used, eng_ctl_pl_empty;

    int n_chk  = 0;
    int n_fail = 0;
    int n_req, n_rew, n_used, n_done, n_bmv, done_cyc;
    int idx_q[$];
    bit finished;

    always #5 clk = ~clk;

    eng_seq_ctrl dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .job_start         (job_start),
        .job_abort         (job_abort),
        .job_grp_num       (job_grp_num),
        .job_pkt_num       (job_pkt_num),
        .job_busy          (job_busy),
        .job_done          (job_done),
        .ctl_err           (ctl_err),
        .ctl_bm_rd_req     (ctl_bm_rd_req),
        .ctl_bm_rd_idx     (ctl_bm_rd_idx),
        .bm_ctl_rd_val     (bm_ctl_rd_val),
        .inbuf_ctl_val     (inbuf_ctl_val),
        .ctl_inbuf_rewind  (ctl_inbuf_rewind),
        .outbuf_ctl_full   (outbuf_ctl_full),
        .ctl_eng_bm_val    (ctl_eng_bm_val),
        .ctl_eng_gl_wr_en  (ctl_eng_gl_wr_en),
        .ctl_eng_din_val   (ctl_eng_din_val),
        .ctl_eng_calc_en   (ctl_eng_calc_en),
        .eng_ctl_data_used (eng_ctl_data_used),
        .eng_ctl_pl_empty  (eng_ctl_pl_empty)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    function automatic int idx_at(input int i);
        return (i < idx_q.size()) ? idx_q[i] : -1;
    endfunction

    // Engine/BM/inbuf responder: BM data one cycle after the request, every offered
    // packet consumed at once, pipeline busy from BM load until 2 cycles after last consume.
    task automatic run_job(input int g, input int p, input int stall_after, input int stall_len,
                           input int abort_after, input int spur_after, input int restart_at,
                           input int max_cyc);
        bit loaded = 0, bm_pend = 0, rdv_now, consumed;
        bit stalled = 0, spurred = 0, aborted = 0;
        int drain = 0, stall_left = 0, stop_at = -1;
        n_req = 0; n_rew = 0; n_used = 0; n_done = 0; n_bmv = 0; done_cyc = -1;
        idx_q.delete();
        finished = 0;
        job_grp_num = GW'(g);
        job_pkt_num = PW'(p);
        job_start   = 1'b1;
        @(posedge clk); #2;
        job_start = 1'b0;
        for (int c = 0; c < max_cyc; c++) begin
            consumed = 0;
            rdv_now  = bm_pend;
            bm_pend  = 0;
            bm_ctl_rd_val     = rdv_now;
            eng_ctl_pl_empty  = !loaded && (drain == 0);
            if (stall_after >= 0 && !stalled && n_used == stall_after) begin
                stalled    = 1;
                stall_left = stall_len;
            end
            outbuf_ctl_full   = (stall_left > 0);
            inbuf_ctl_val     = 1'b1;
            eng_ctl_data_used = 1'b0;
            job_abort         = 1'b0;
            job_start         = 1'b0;
            if (spur_after >= 0 && !spurred && n_used == spur_after) begin
                spurred           = 1;
                inbuf_ctl_val     = 1'b0;
                eng_ctl_data_used = 1'b1;
            end
            if (abort_after >= 0 && !aborted && n_used == abort_after) begin
                aborted   = 1;
                job_abort = 1'b1;
                stop_at   = c + 4;
            end
            if (c == restart_at) begin
                job_grp_num = GW'(5);
                job_pkt_num = PW'(1);
                job_start   = 1'b1;
            end
            #1;
            if (outbuf_ctl_full) begin
                chk("stall_din_val", ctl_eng_din_val, 0);
                chk("stall_calc_en", ctl_eng_calc_en, 0);
            end
            if (job_abort) chk("abort_busy_before", job_busy, 1);
            if (aborted && c == stop_at - 3) chk("abort_busy_next", job_busy, 0);
            if (ctl_eng_din_val) begin
                consumed          = 1;
                n_used++;
                eng_ctl_data_used = 1'b1;
            end
            if (ctl_bm_rd_req) begin
                n_req++;
                idx_q.push_back(int'(ctl_bm_rd_idx));
                bm_pend = 1;
            end
            if (rdv_now && ctl_eng_bm_val && ctl_eng_gl_wr_en) n_bmv++;
            if (ctl_inbuf_rewind) n_rew++;
            if (job_done) begin
                n_done++;
                if (done_cyc < 0) done_cyc = c;
            end
            @(posedge clk); #2;
            if (stall_left > 0) stall_left--;
            if (consumed) begin
                loaded = 0;
                drain  = 2;
            end else if (drain > 0) begin
                drain--;
            end
            if (rdv_now) loaded = 1;
            if (done_cyc >= 0) begin
                finished = 1;
                break;
            end
            if (c == stop_at) break;
        end
        job_abort         = 1'b0;
        job_start         = 1'b0;
        eng_ctl_data_used = 1'b0;
        bm_ctl_rd_val     = 1'b0;
        outbuf_ctl_full   = 1'b0;
        if (abort_after < 0) chk("job_finished_in_budget", finished, 1);
    endtask

    initial begin
        rst_n = 1'b0; job_start = 1'b0; job_abort = 1'b0;
        job_grp_num = '0; job_pkt_num = '0;
        bm_ctl_rd_val = 1'b0; inbuf_ctl_val = 1'b0; outbuf_ctl_full = 1'b0;
        eng_ctl_data_used = 1'b0; eng_ctl_pl_empty = 1'b0;
        repeat (3) @(posedge clk);
        #2;
        chk("rst_busy", job_busy, 0);
        chk("rst_done", job_done, 0);
        chk("rst_err", ctl_err, 0);
        chk("rst_rd_req", ctl_bm_rd_req, 0);
        chk("rst_rd_idx", ctl_bm_rd_idx, 0);
        chk("rst_rewind", ctl_inbuf_rewind, 0);
        chk("rst_bm_val", ctl_eng_bm_val, 0);
        chk("rst_gl_wr", ctl_eng_gl_wr_en, 0);
        chk("rst_din_val", ctl_eng_din_val, 0);
        chk("rst_calc_en", ctl_eng_calc_en, 0);
        rst_n = 1'b1;
        @(posedge clk); #2;

        // single group, four packets
        run_job(1, 4, -1, 0, -1, -1, -1, 200);
        chk("t1_req", n_req, 1);
        chk("t1_idx0", idx_at(0), 0);
        chk("t1_used", n_used, 4);
        chk("t1_done", n_done, 1);
        chk("t1_rewind", n_rew, 0);
        chk("t1_bm_load", n_bmv, 1);
        chk("t1_busy_after", job_busy, 0);

        // minimal job latency: start cycle to done = 8 with this engine's drain
        run_job(1, 1, -1, 0, -1, -1, -1, 200);
        chk("lat_done_cyc", done_cyc, 7);
        chk("lat_used", n_used, 1);

        // three groups of two packets
        run_job(3, 2, -1, 0, -1, -1, -1, 300);
        chk("t2_req", n_req, 3);
        chk("t2_idx0", idx_at(0), 0);
        chk("t2_idx1", idx_at(1), 1);
        chk("t2_idx2", idx_at(2), 2);
        chk("t2_rewind", n_rew, 2);
        chk("t2_used", n_used, 6);
        chk("t2_done", n_done, 1);

        // outbuf full for five cycles after the second packet
        run_job(1, 4, 2, 5, -1, -1, -1, 200);
        chk("t3_used", n_used, 4);
        chk("t3_done", n_done, 1);
        chk("t3_busy_after", job_busy, 0);

        // abort in the drain of group 1, then a clean job
        run_job(2, 2, -1, 0, 4, -1, -1, 200);
        chk("t4_done", n_done, 0);
        chk("t4_busy", job_busy, 0);
        chk("t4_req", n_req, 2);
        chk("t4_rewind", n_rew, 1);
        run_job(1, 2, -1, 0, -1, -1, -1, 200);
        chk("t4b_idx0", idx_at(0), 0);
        chk("t4b_req", n_req, 1);
        chk("t4b_done", n_done, 1);

        // empty jobs finish immediately
        run_job(3, 0, -1, 0, -1, -1, -1, 20);
        chk("t5_p0_done_cyc", done_cyc, 0);
        chk("t5_p0_req", n_req, 0);
        run_job(0, 5, -1, 0, -1, -1, -1, 20);
        chk("t5_g0_done_cyc", done_cyc, 0);
        chk("t5_g0_req", n_req, 0);

        // job_start while busy must not reload G/P
        run_job(1, 3, -1, 0, -1, -1, 1, 200);
        chk("t5b_used", n_used, 3);
        chk("t5b_req", n_req, 1);
        chk("t5b_done", n_done, 1);
        chk("t5b_busy_after", job_busy, 0);

        // spurious consume sets sticky error without counting
        run_job(1, 3, -1, 0, -1, 1, -1, 200);
        chk("t6_err", ctl_err, 1);
        chk("t6_used", n_used, 3);
        chk("t6_done", n_done, 1);
        repeat (2) @(posedge clk);
        #2;
        chk("t6_err_sticky", ctl_err, 1);
        run_job(1, 1, -1, 0, -1, -1, -1, 200);
        chk("t6_err_cleared", ctl_err, 0);
        chk("t6b_done", n_done, 1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
